// File: rtl/mon_chain_reader.sv
// Reads the serialized CIC integrator chain, computes the per-channel two-stage comb
// (differentiator), scales and saturates the result, and polices frame length.
module mon_chain_reader #(
    parameter int rwi   = 28,
    parameter int nchan = 2,
    parameter int owi   = 20,
    parameter int shift = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  samp,
    input  logic signed [rwi-1:0] s_in,
    input  logic                  g_in,
    input  logic                  err_clr,
    output logic signed [owi-1:0] r_out,
    output logic        [3:0]     r_chan,
    output logic                  r_valid,
    output logic                  frame_done,
    output logic                  err_count,
    output logic                  err_sat
);
    localparam int ciw   = (nchan > 1) ? $clog2(nchan) : 1;
    localparam int depth = 1 << ciw;
    localparam logic [4:0] nchan_w = 5'(nchan);
    localparam logic signed [rwi-1:0] o_max = {{(rwi-owi+1){1'b0}}, {(owi-1){1'b1}}};
    localparam logic signed [rwi-1:0] o_min = {{(rwi-owi+1){1'b1}}, {(owi-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, END} state_t;

    state_t state, state_nxt;

    logic [4:0] cnt, idx, frm_cnt, done_cnt;
    logic       accept, discard, in_end, frame_close;

    // NOTE: every signal assigned in an always_comb gets a value on every path, so no latches.
    always_comb begin
        idx     = samp ? 5'd0 : cnt;
        accept  = g_in && (idx < nchan_w);
        discard = g_in && !accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= idx + 5'd1;
        end else if (samp) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A non-zero frm_cnt in END means samp already opened the next frame; keep running it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (samp || !g_in) state_nxt = END;
            END:     state_nxt = (accept || frm_cnt != 5'd0) ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_done  = (state == END);
        in_end      = (state == END);
        frame_close = (state == RUN) && (samp || !g_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt  <= '0;
            done_cnt <= '0;
        end else if (frame_close) begin
            done_cnt <= frm_cnt;
            frm_cnt  <= {4'd0, accept};
        end else if (in_end && samp) begin
            frm_cnt <= {4'd0, accept};
        end else if (accept) begin
            frm_cnt <= frm_cnt + 5'd1;
        end
    end

    // Stage 0: capture the accepted word and its channel.
    logic                  acc0;
    logic [ciw-1:0]        ch0;
    logic signed [rwi-1:0] x0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc0 <= 1'b0;
            ch0  <= '0;
            x0   <= '0;
        end else begin
            acc0 <= accept;
            ch0  <= idx[ciw-1:0];
            x0   <= s_in;
        end
    end

    // Stage 1: comb differences against per-channel history.
    logic signed [rwi-1:0] x_prev  [depth];
    logic signed [rwi-1:0] d1_prev [depth];
    logic        [1:0]     prime   [depth];
    logic signed [rwi-1:0] d1, d2, d2_q;
    logic                  primed, v1;
    logic [ciw-1:0]        ch1;

    always_comb begin
        d1     = x0 - x_prev[ch0];
        d2     = d1 - d1_prev[ch0];
        primed = (prime[ch0] == 2'd2);
    end

    // NOTE: the history is a handful of flops, not a RAM, so it is cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                x_prev[i]  <= '0;
                d1_prev[i] <= '0;
                prime[i]   <= '0;
            end
            d2_q <= '0;
            ch1  <= '0;
            v1   <= 1'b0;
        end else begin
            v1   <= acc0 && primed;
            ch1  <= ch0;
            d2_q <= d2;
            if (acc0) begin
                x_prev[ch0]  <= x0;
                d1_prev[ch0] <= d1;
                if (!primed) prime[ch0] <= prime[ch0] + 2'd1;
            end
        end
    end

    // Stage 2: scale, saturate and present.
    logic signed [rwi-1:0] sh;
    logic signed [owi-1:0] res;
    logic                  sat;

    always_comb begin
        sh  = d2_q >>> shift;
        sat = 1'b1;
        if (sh > o_max) begin
            res = o_max[owi-1:0];
        end else if (sh < o_min) begin
            res = o_min[owi-1:0];
        end else begin
            res = sh[owi-1:0];
            sat = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= v1;
            if (v1) begin
                r_out  <= res;
                r_chan <= 4'(ch1);
            end
        end
    end

    // Sticky flags: a set event in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 1'b0;
            err_sat   <= 1'b0;
        end else begin
            if (discard || (in_end && done_cnt != nchan_w)) begin
                err_count <= 1'b1;
            end else if (err_clr) begin
                err_count <= 1'b0;
            end
            if (v1 && sat) begin
                err_sat <= 1'b1;
            end else if (err_clr) begin
                err_sat <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mon_chain_reader.sv
// Self-checking bench for mon_chain_reader: directed scenarios plus random frames,
// two instances (shift 0 and shift 4) checked against a frame-level reference model.
module tb_mon_chain_reader;
    localparam int RWI = 28;
    localparam int NCH = 2;
    localparam int OWI = 20;
    localparam int SH0 = 0;
    localparam int SH1 = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  samp = 1'b0;
    logic                  g_in = 1'b0;
    logic                  err_clr = 1'b0;
    logic signed [RWI-1:0] s_in = '0;

    logic signed [OWI-1:0] r_out0, r_out1;
    logic [3:0]            r_chan0, r_chan1;
    logic                  r_valid0, r_valid1, fd0, fd1, ec0, ec1, es0, es1;

    always #5 clk = ~clk;

    mon_chain_reader #(.rwi(RWI), .nchan(NCH), .owi(OWI), .shift(SH0)) dut0 (
        .clk(clk), .rst_n(rst_n), .samp(samp), .s_in(s_in), .g_in(g_in), .err_clr(err_clr),
        .r_out(r_out0), .r_chan(r_chan0), .r_valid(r_valid0), .frame_done(fd0),
        .err_count(ec0), .err_sat(es0)
    );

    mon_chain_reader #(.rwi(RWI), .nchan(NCH), .owi(OWI), .shift(SH1)) dut1 (
        .clk(clk), .rst_n(rst_n), .samp(samp), .s_in(s_in), .g_in(g_in), .err_clr(err_clr),
        .r_out(r_out1), .r_chan(r_chan1), .r_valid(r_valid1), .frame_done(fd1),
        .err_count(ec1), .err_sat(es1)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit                  v;
        int                  ch;
        bit signed [OWI-1:0] o0;
        bit signed [OWI-1:0] o1;
        bit                  s0;
        bit                  s1;
    } ent_t;

    // Reference model state
    ent_t                  e1, e2;
    logic signed [RWI-1:0] m_xp [NCH];
    logic signed [RWI-1:0] m_dp [NCH];
    int                    m_n  [NCH];
    int                    m_since, m_fcnt, m_ccnt;
    bit                    m_in, m_chk, x_ec, x_es0, x_es1;

    // Observation counters
    int                    fd_seen, rv_seen, ch0_seen, first_ch;
    logic signed [OWI-1:0] last_ch0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        e1 = '{default: 0};
        e2 = '{default: 0};
        for (int i = 0; i < NCH; i++) begin
            m_xp[i] = '0;
            m_dp[i] = '0;
            m_n[i]  = 0;
        end
        m_since = 0;
        m_fcnt  = 0;
        m_ccnt  = 0;
        m_in    = 0;
        m_chk   = 0;
        x_ec    = 0;
        x_es0   = 0;
        x_es1   = 0;
    endfunction

    // Floor-divide by 2^sh, then clamp into the signed OWI range.
    function automatic void scale(input logic signed [RWI-1:0] d, input int sh,
                                  output bit signed [OWI-1:0] o, output bit sat);
        longint q, hi, lo;
        q   = longint'(d) >>> sh;
        hi  = (longint'(1) << (OWI - 1)) - 1;
        lo  = -hi - 1;
        sat = 1'b1;
        if (q > hi) o = OWI'(hi);
        else if (q < lo) o = OWI'(lo);
        else begin
            o   = OWI'(q);
            sat = 1'b0;
        end
    endfunction

    function automatic logic signed [RWI-1:0] rnd_word();
        int v;
        if ($urandom_range(0, 1) == 1) return RWI'($urandom);
        v = int'($urandom_range(0, 4000)) - 2000;
        return RWI'(v);
    endfunction

    task automatic step(input bit s, input bit g, input logic signed [RWI-1:0] x, input bit clr);
        ent_t ne, xo;
        int   idx;
        bit   a, disc, fd_x, set_ec;
        samp    = s;
        g_in    = g;
        s_in    = x;
        err_clr = clr;

        idx  = s ? 0 : m_since;
        a    = g && (idx < NCH);
        disc = g && !a;
        ne   = '{default: 0};
        if (a) begin
            logic signed [RWI-1:0] d1, d2;
            bit signed [OWI-1:0]   o0, o1;
            bit                    s0, s1;
            d1 = x - m_xp[idx];
            d2 = d1 - m_dp[idx];
            scale(d2, SH0, o0, s0);
            scale(d2, SH1, o1, s1);
            ne.v  = (m_n[idx] >= 2);
            ne.ch = idx;
            ne.o0 = o0;
            ne.o1 = o1;
            ne.s0 = s0;
            ne.s1 = s1;
            m_xp[idx] = x;
            m_dp[idx] = d1;
            m_n[idx]++;
            m_since = idx + 1;
        end else if (s) begin
            m_since = 0;
        end
        xo = e2;
        e2 = e1;
        e1 = ne;

        set_ec = disc || (m_chk && m_ccnt != NCH);
        m_chk  = 0;
        fd_x   = 0;
        if (m_in && (s || !g)) begin
            fd_x   = 1;
            m_ccnt = m_fcnt;
            m_chk  = 1;
            m_in   = a;
            m_fcnt = a ? 1 : 0;
        end else if (a) begin
            m_in = 1;
            m_fcnt++;
        end
        if (set_ec) x_ec = 1;
        else if (clr) x_ec = 0;
        if (xo.v && xo.s0) x_es0 = 1;
        else if (clr) x_es0 = 0;
        if (xo.v && xo.s1) x_es1 = 1;
        else if (clr) x_es1 = 0;

        @(posedge clk);
        #1;
        check("valid0", r_valid0, xo.v);
        check("valid1", r_valid1, xo.v);
        if (xo.v) begin
            check("chan0", r_chan0, xo.ch);
            check("chan1", r_chan1, xo.ch);
            check("out0", r_out0, xo.o0);
            check("out1", r_out1, xo.o1);
        end
        check("frame_done0", fd0, fd_x);
        check("frame_done1", fd1, fd_x);
        check("err_count0", ec0, x_ec);
        check("err_count1", ec1, x_ec);
        check("err_sat0", es0, x_es0);
        check("err_sat1", es1, x_es1);

        fd_seen += int'(fd0);
        if (r_valid0) rv_seen++;
        if (r_valid0 && first_ch < 0) first_ch = int'(r_chan0);
        if (r_valid0 && r_chan0 == 4'd0) begin
            ch0_seen++;
            last_ch0 = r_out0;
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n   = 1'b0;
        samp    = 1'b0;
        g_in    = 1'b0;
        err_clr = 1'b0;
        #1;
        check("rst_r_out", r_out0, 0);
        check("rst_r_chan", r_chan0, 0);
        check("rst_r_valid", r_valid0, 0);
        check("rst_frame_done", fd0, 0);
        check("rst_err_count", ec0, 0);
        check("rst_err_sat", es0, 0);
        check("rst_r_valid1", r_valid1, 0);
        repeat (cycles) @(negedge clk);
        check("rst_frame_done_hold", fd0, 0);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic frame(input logic signed [RWI-1:0] w0, input logic signed [RWI-1:0] w1,
                         input int gap);
        step(1'b1, 1'b1, w0, 1'b0);
        step(1'b0, 1'b1, w1, 1'b0);
        repeat (gap) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int fd_before;
        first_ch = -1;
        fd_seen  = 0;
        rv_seen  = 0;
        ch0_seen = 0;
        last_ch0 = '0;
        model_clear();
        do_reset(3);

        // Constant words: outputs appear from frame 3 and are zero
        fd_seen = 0;
        rv_seen = 0;
        repeat (4) frame(28'sd1000, -28'sd500, 1);
        repeat (2) step(1'b0, 1'b0, '0, 1'b0);
        check("const_frame_done_count", fd_seen, 4);
        check("const_valid_count", rv_seen, 4);
        check("const_ch0_out", last_ch0, 0);

        // Quadratic ramp on channel 0
        do_reset(2);
        ch0_seen = 0;
        frame(28'sd0, 28'sd0, 1);
        frame(28'sd10, 28'sd0, 1);
        frame(28'sd30, 28'sd0, 1);
        frame(28'sd60, 28'sd0, 1);
        repeat (2) step(1'b0, 1'b0, '0, 1'b0);
        check("ramp_ch0_count", ch0_seen, 2);
        check("ramp_ch0_out", last_ch0, 10);

        // Wrap from the top of the range to the bottom: d1 = 1
        do_reset(2);
        frame(28'sh7FFFFFF, 28'sd0, 1);
        frame(28'sh7FFFFFF, 28'sd0, 1);
        frame(28'sh8000000, 28'sd0, 1);
        repeat (2) step(1'b0, 1'b0, '0, 1'b0);
        check("wrap_ch0_out", last_ch0, 1);
        check("wrap_no_sat", es0, 0);

        // Positive saturation
        do_reset(2);
        frame(28'sd0, 28'sd0, 1);
        frame(28'sd0, 28'sd0, 1);
        frame(28'sh4000000, 28'sd0, 1);
        repeat (2) step(1'b0, 1'b0, '0, 1'b0);
        check("sat_ch0_out", last_ch0, 524287);
        check("sat_flag0", es0, 1);
        check("sat_flag1", es1, 1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Three gated words: the third is dropped and err_count sticks
        step(1'b1, 1'b1, 28'sd5, 1'b0);
        step(1'b0, 1'b1, 28'sd6, 1'b0);
        step(1'b0, 1'b1, 28'sd7, 1'b0);
        repeat (4) step(1'b0, 1'b0, '0, 1'b0);
        check("overrun_err_held", ec0, 1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Partial frame, with err_clr colliding with the set event
        step(1'b1, 1'b1, 28'sd9, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        check("partial_set_wins", ec0, 1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Random frames, back-to-back or with gaps
        for (int f = 0; f < 40; f++) begin
            step(1'b1, 1'b1, rnd_word(), $urandom_range(0, 7) == 0);
            step(1'b0, 1'b1, rnd_word(), $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, '0, $urandom_range(0, 7) == 0);
        end
        repeat (3) step(1'b0, 1'b0, '0, 1'b0);

        // Reset mid-frame: no frame_done, history and indexing restart
        step(1'b1, 1'b1, 28'sd123, 1'b0);
        do_reset(2);
        fd_before = fd_seen;
        repeat (2) step(1'b0, 1'b0, '0, 1'b0);
        check("midrst_no_frame_done", fd_seen, fd_before);
        first_ch = -1;
        rv_seen  = 0;
        frame(28'sd40, 28'sd50, 1);
        frame(28'sd41, 28'sd52, 1);
        frame(28'sd43, 28'sd55, 1);
        repeat (2) step(1'b0, 1'b0, '0, 1'b0);
        check("midrst_valid_count", rv_seen, 2);
        check("midrst_first_chan", first_ch, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mon_chain_reader.md
MON_CHAIN_READER -- requirements
Module: mon_chain_reader

Interface
REQ-001 SHALL have parameter rwi, default 28: stream word width, equal to the chain result width.
REQ-002 SHALL have parameter nchan, default 2: number of words per frame (channels in the chain), range 1..16.
REQ-003 SHALL have parameter owi, default 20: output result width, owi <= rwi.
REQ-004 SHALL have parameter shift, default 8: arithmetic right shift applied after differentiation, 0 <= shift <= rwi-owi.
REQ-005 SHALL have port clk, input, 1: sole clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port samp, input, 1: frame strobe, same strobe that loads the serializer chain.
REQ-008 SHALL have port s_in, input signed, rwi: stream word from the end of the serializer chain.
REQ-009 SHALL have port g_in, input, 1: gate; s_in is valid when g_in=1.
REQ-010 SHALL have port err_clr, input, 1: clears the sticky error flags.
REQ-011 SHALL have port r_out, output signed, owi: differentiated, scaled channel result.
REQ-012 SHALL have port r_chan, output, 4: channel index of r_out.
REQ-013 SHALL have port r_valid, output, 1: one-cycle strobe qualifying r_out and r_chan.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse at end of frame.
REQ-015 SHALL have port err_count, output, 1: sticky flag, frame word count differed from nchan.
REQ-016 SHALL have port err_sat, output, 1: sticky flag, r_out saturated.

Function
REQ-017 Word index SHALL be 0 for a word accepted in the same cycle as samp=1; otherwise it SHALL be the number of words accepted since the last samp.
REQ-018 A word SHALL be accepted on each cycle with g_in=1 while the word index is < nchan.
REQ-019 Words arriving with index >= nchan SHALL be discarded and SHALL set err_count.
REQ-020 Per channel, the block SHALL keep x_prev and d1_prev (rwi bits each); a channel is 0 at reset.
REQ-021 For an accepted word x on channel c, the block SHALL compute d1 = x - x_prev[c] and d2 = d1 - d1_prev[c], modulo 2^rwi (wrap-around is intended CIC arithmetic).
REQ-022 On acceptance, x_prev[c] SHALL be updated to x and d1_prev[c] to d1.
REQ-023 r_out SHALL equal d2 >>> shift, saturated to the signed owi range; any saturation SHALL set err_sat.
REQ-024 Latency SHALL be exactly 2 cycles: the word accepted at edge N yields r_valid=1 after edge N+2, with pipeline registers for r_chan and r_out.
REQ-025 Each channel SHALL have a 2-bit prime counter; r_valid SHALL be suppressed for a channel's first two accepted words after reset, while history still updates.
REQ-026 The frame state machine SHALL have three states: IDLE, RUN and END.
REQ-027 IDLE SHALL go to RUN on the first accepted word.
REQ-028 RUN SHALL go to END on the first cycle with g_in=0, or when samp=1.
REQ-029 END SHALL pulse frame_done for one cycle, set err_count if the accepted count != nchan, then return to IDLE, or to RUN if a word is accepted that cycle.
REQ-030 If samp=1 and g_in=1 in the same cycle while in RUN, the block SHALL close the old frame (frame_done next cycle) and count the word as index 0 of the new frame.
REQ-031 Gaps (g_in=0) SHALL end a frame; a partial frame SHALL be processed normally and flagged via err_count.
REQ-032 err_clr SHALL clear both flags; if a set event occurs in the same cycle, set SHALL win.

Reset
REQ-033 While rst_n=0, the block SHALL force r_out=0, r_chan=0, r_valid=0, frame_done=0, err_count=0 and err_sat=0.
REQ-034 While rst_n=0, the block SHALL clear all x_prev, d1_prev and prime counters, and set the state to IDLE.
REQ-035 Reset asserted mid-frame SHALL discard the frame with no frame_done pulse; the first post-reset frame SHALL start at index 0.

Verification
REQ-036 The bench SHALL cover this scenario: nchan=2, shift=0; frames of constant words ch0=1000, ch1=-500 for 4 frames -> r_valid only from frame 3 onward, r_out=0 for both channels, frame_done pulses once per frame.
REQ-037 The bench SHALL cover this scenario: ch0 words 0, 10, 30, 60 (quadratic ramp) -> frames 3 and 4 give r_out=10, r_chan=0, 2 cycles after acceptance.
REQ-038 The bench SHALL cover this scenario: x_prev=2^27-1 then x=-2^27, wrap -> d1=1, no err_sat.
REQ-039 The bench SHALL cover this scenario: 3 gated words with nchan=2 -> third word dropped, err_count=1, held until err_clr.
REQ-040 The bench SHALL cover this scenario: d2 = 2^26 with shift=0, owi=20 -> r_out=524287, err_sat=1.
REQ-041 The bench SHALL cover this scenario: rst_n pulsed low after the first word of a frame -> all outputs 0, no frame_done, next frame begins at r_chan 0 and is unprimed.
